wc_tile_feeder: RTL and testbench
=================================

WC_TILE_FEEDER -- requirements
Module: wc_tile_feeder

Interface
REQ-001 Parameter DW, 10: sample width in bits.
REQ-002 Parameter TILE, 5: window length in samples (F(2,4): 2 outputs + 4 taps - 1).
REQ-003 Parameter STRIDE, 2: new samples per window after the first window of a row.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Port in_valid  in  1: in_data/in_last are valid.
REQ-007 Port in_ready  out  1: feeder accepts a sample this cycle.
REQ-008 Port in_data  in  DW: signed sample.
REQ-009 Port in_last  in  1: marks the final sample of a row.
REQ-010 Port out_valid  out  1: out_D holds a complete window.
REQ-011 Port out_ready  in  1: the downstream Winograd core consumes the window.
REQ-012 Port out_D  out  DW*TILE (50): packed window. out_D[DW*k +: DW] = sample k, where k=0 is the oldest.
REQ-013 Port out_last  out  1: the window is the last window of its row.

Function
REQ-014 Sample transfer occurs only when in_valid && in_ready. Window transfer occurs only when out_valid && out_ready.
REQ-015 in_ready SHALL be (!out_valid || out_ready) && state != PAD.
REQ-016 Samples enter a TILE-deep shift window. A new sample goes in at position TILE-1; older samples shift toward 0.
REQ-017 The state machine has three states:
- FILL (reset state): collect TILE samples.
- STEP: collect STRIDE samples.
- PAD: insert zero samples.
REQ-018 FILL: when the TILE-th sample is accepted, out_valid asserts on the next cycle, and the state becomes STEP with count 0.
REQ-019 STEP: when the STRIDE-th sample is accepted, a window is emitted on the next cycle.
- Overlap with the previous window is TILE-STRIDE = 3 samples.
REQ-020 Latency from accepting the completing sample to out_valid is exactly 1 cycle.
REQ-021 out_D, out_last and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 If a window transfer and a window-completing sample acceptance happen in the same cycle, the new window is presented on the next cycle with no bubble.
REQ-023 in_last on a sample that completes a window: emit that window with out_last=1, then return to FILL with the window cleared to 0.
REQ-024 in_last on a sample that leaves a window incomplete: enter PAD.
- PAD inserts one zero sample per cycle, only while the output register is free.
- The number of zeros equals the samples still missing: TILE-n in FILL, STRIDE-n in STEP.
- The padded window is emitted with out_last=1.
- The state then returns to FILL.
REQ-025 A row shorter than TILE samples yields exactly one zero-padded window. Example: a single sample s gives {s,0,0,0,0} with s at k=0.
REQ-026 Sample count registers wrap to 0 at window completion and never exceed TILE-1.
REQ-027 Samples pass through unmodified. No arithmetic is performed on data.

Reset
REQ-028 Asserting rst clears the following to 0, immediately and without regard to clk: out_valid, out_last, out_D, the window, the counts and tile_cnt. The state goes to FILL.
REQ-029 rst asserted mid-row or mid-PAD discards the partial window. No window is emitted for it.
REQ-030 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.

Configuration
REQ-031 Macro WC_FEEDER_CNT_EN:
- When defined, add output port tile_cnt (16 bits). It increments on every window transfer, wraps from 65535 to 0, and resets to 0.
- When undefined, the port and its counter are absent, and all other behaviour is identical.

Verification
REQ-032 Row 1..9 with in_last on 9, out_ready=1 -> windows {1..5}, {3..7}, {5..9}; out_last=1 only on {5..9}.
REQ-033 Row 1..8 with in_last on 8 -> windows {1..5}, {3..7}, {5,6,7,8,0} with out_last=1; in_ready=0 for 1 PAD cycle.
REQ-034 Row 7,8 with in_last on 8 -> one window {7,8,0,0,0} with out_last=1 after 3 PAD cycles, then FILL.
REQ-035 out_ready held 0 for 4 cycles while window {1..5} is pending -> out_D stays stable, in_ready=0; the window transfers once out_ready=1, with no sample lost or duplicated.
REQ-036 rst pulsed after samples 1,2,3 have been accepted -> out_valid=0 immediately; new row 10..14 yields {10..14} with no residue from the old samples.
REQ-037 WC_FEEDER_CNT_EN defined, 65537 windows transferred -> tile_cnt=1.

Source files
------------

// File: rtl/wc_tile_feeder.sv
// Sliding-window feeder for a Winograd F(2,4) core: builds TILE-sample windows
// advancing by STRIDE, zero-pads short row tails. Optional WC_FEEDER_CNT_EN adds tile_cnt.
module wc_tile_feeder #(
  parameter int DW     = 10,
  parameter int TILE   = 5,
  parameter int STRIDE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW*TILE-1:0]   out_D,
  output logic                 out_last
`ifdef WC_FEEDER_CNT_EN
  ,
  output logic [15:0]          tile_cnt
`endif
);

  localparam int CW = $clog2(TILE + 1);
  localparam int WW = DW * TILE;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_STEP = 2'd1,
    S_PAD  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [WW-1:0] r_win, w_win_nxt;
  logic          r_pad_fill, w_pad_fill_nxt;
  logic          r_out_valid;
  logic          r_out_last;
  logic [WW-1:0] r_out_D;

  logic          w_out_free;
  logic          w_acc;
  logic          w_pad_go;
  logic          w_step;
  logic          w_done;
  logic          w_emit;
  logic          w_emit_last;
  logic [CW-1:0] w_target;
  logic [CW-1:0] w_cnt_inc;
  logic [DW-1:0] w_shift_in;
  logic [WW-1:0] w_shifted;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = w_out_free && (r_state != S_PAD) && !rst;
  assign w_acc      = in_valid && in_ready;
  assign w_pad_go   = (r_state == S_PAD) && w_out_free;
  assign w_step     = w_acc || w_pad_go;

  // r_pad_fill remembers whether the row ended before the first window was full
  assign w_target   = ((r_state == S_FILL) || ((r_state == S_PAD) && r_pad_fill))
                      ? CW'(TILE) : CW'(STRIDE);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_done     = w_step && (w_cnt_inc == w_target);

  // Newest sample enters at the top slot; slot 0 (oldest) falls off
  assign w_shift_in = w_pad_go ? '0 : in_data;
  assign w_shifted  = {w_shift_in, r_win[WW-1:DW]};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_win_nxt      = r_win;
    w_pad_fill_nxt = r_pad_fill;
    w_emit         = 1'b0;
    w_emit_last    = 1'b0;
    if (w_step) begin
      w_win_nxt = w_shifted;
      w_cnt_nxt = w_cnt_inc;
      if (w_done) begin
        w_emit    = 1'b1;
        w_cnt_nxt = '0;
        if (w_pad_go || in_last) begin
          w_emit_last = 1'b1;
          w_state_nxt = S_FILL;
          w_win_nxt   = '0;
        end else begin
          w_state_nxt = S_STEP;
        end
      end else if (w_acc && in_last) begin
        w_state_nxt    = S_PAD;
        w_pad_fill_nxt = (r_state == S_FILL);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_win      <= '0;
      r_pad_fill <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_win      <= w_win_nxt;
      r_pad_fill <= w_pad_fill_nxt;
    end
  end

  // Output register: a completing step always finds it free, so load wins over drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_D     <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_emit_last;
      r_out_D     <= w_shifted;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_D     = r_out_D;

`ifdef WC_FEEDER_CNT_EN
  logic [15:0] r_tile_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_tile_cnt <= r_tile_cnt + 16'd1;
    end
  end

  assign tile_cnt = r_tile_cnt;
`endif

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Self-checking bench for wc_tile_feeder: cycle table, directed corner sequences,
// and randomized rows checked against a row-level window model.
module tb_wc_tile_feeder;
  localparam int DW     = 10;
  localparam int TILE   = 5;
  localparam int STRIDE = 2;
  localparam int WW     = DW * TILE;
  localparam logic H = 1'b1;
  localparam logic Z = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [WW-1:0] out_D;
`ifdef WC_FEEDER_CNT_EN
  logic [15:0]   tile_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  bit rnd_or  = 1'b0;

  typedef struct packed {
    logic [WW-1:0] d;
    logic          last;
  } win_t;
  win_t exp_q[$];
  win_t obs_q[$];

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          il;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic          e_ol;
    logic [WW-1:0] e_D;
  } vec_t;
  vec_t vt[11];

  wc_tile_feeder #(.DW(DW), .TILE(TILE), .STRIDE(STRIDE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_D    (out_D),
    .out_last (out_last)
`ifdef WC_FEEDER_CNT_EN
    ,
    .tile_cnt (tile_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transfers are sampled mid-cycle; inputs only change just after the rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      win_t w;
      w.d    = out_D;
      w.last = out_last;
      obs_q.push_back(w);
      xfers++;
    end
  end

  always @(posedge clk) begin
    if (rnd_or) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkwin(input int a, input int b, input int c,
                                          input int d, input int e);
    logic [WW-1:0] r;
    r = '0;
    r[0*DW +: DW] = DW'(a);
    r[1*DW +: DW] = DW'(b);
    r[2*DW +: DW] = DW'(c);
    r[3*DW +: DW] = DW'(d);
    r[4*DW +: DW] = DW'(e);
    return r;
  endfunction

  function automatic vec_t mkv(input logic iv, input int d, input logic il, input logic ordy,
                               input logic ir, input logic ov, input logic ol,
                               input logic [WW-1:0] dd);
    vec_t v;
    v.iv = iv; v.d = DW'(d); v.il = il; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_ol = ol; v.e_D = dd;
    return v;
  endfunction

  // Row model: window j covers samples j*STRIDE .. j*STRIDE+TILE-1, zeros past the row end
  task automatic model_row(input int s[$]);
    int len, nw, idx;
    win_t w;
    len = s.size();
    nw  = (len <= TILE) ? 1 : 1 + (len - TILE + STRIDE - 1) / STRIDE;
    for (int j = 0; j < nw; j++) begin
      w.d = '0;
      for (int k = 0; k < TILE; k++) begin
        idx = j * STRIDE + k;
        if (idx < len) w.d[k*DW +: DW] = DW'(s[idx]);
      end
      w.last = (j == nw - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic send(input int d, input logic last, input int gap);
    bit acc;
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    acc = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: sample %0d not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic send_row(input int s[$], input int maxgap);
    model_row(s);
    for (int i = 0; i < s.size(); i++)
      send(s[i], (i == s.size() - 1), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic check_windows(input string name);
    int n, m;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_D%0d", name, i), 64'(obs_q[i].d), 64'(exp_q[i].d));
      chk($sformatf("%s_last%0d", name, i), 64'(obs_q[i].last), 64'(exp_q[i].last));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    xfers = 0;
  endtask

  initial begin
    int q[$];
    int cnt;

    vt[0]  = mkv(H, 1, Z, H, H, Z, Z, '0);
    vt[1]  = mkv(H, 2, Z, H, H, Z, Z, '0);
    vt[2]  = mkv(H, 3, Z, H, H, Z, Z, '0);
    vt[3]  = mkv(H, 4, Z, H, H, Z, Z, '0);
    vt[4]  = mkv(H, 5, Z, H, H, Z, Z, '0);
    vt[5]  = mkv(H, 6, Z, H, H, H, Z, mkwin(1, 2, 3, 4, 5));
    vt[6]  = mkv(H, 7, Z, H, H, Z, Z, '0);
    vt[7]  = mkv(H, 8, H, H, H, H, Z, mkwin(3, 4, 5, 6, 7));
    vt[8]  = mkv(Z, 0, Z, H, Z, Z, Z, '0);
    vt[9]  = mkv(Z, 0, Z, H, H, H, H, mkwin(5, 6, 7, 8, 0));
    vt[10] = mkv(Z, 0, Z, H, H, Z, Z, '0);

    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_D", 64'(out_D), 64'(0));
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Cycle-by-cycle table: row 1..8 ending mid-step, one PAD cycle
    for (int i = 0; i < 11; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; in_last = vt[i].il; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      if (vt[i].e_ov) begin
        chk($sformatf("tbl%0d_out_D", i), 64'(out_D), 64'(vt[i].e_D));
        chk($sformatf("tbl%0d_out_last", i), 64'(out_last), 64'(vt[i].e_ol));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    obs_q.delete();
    exp_q.delete();

    // Row 1..9 ending exactly on a window
    q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_row(q, 0);
    check_windows("row9");

    // Short row 7,8: three PAD cycles
    q = {7, 8};
    model_row(q);
    send(7, 1'b0, 0);
    send(8, 1'b1, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!in_ready) cnt++;
      @(posedge clk); #1;
    end
    chk("pad_cycles", 64'(cnt), 64'(3));
    check_windows("row2");

    q = {99};
    send_row(q, 0);
    check_windows("row1");

    // Backpressure on the first window
    q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
    model_row(q);
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0, 0);
    in_valid = 1'b1; in_data = DW'(6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("stall%0d_out_D", i), 64'(out_D), 64'(mkwin(1, 2, 3, 4, 5)));
      chk($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 6; i <= 9; i++) send(i, (i == 9), 0);
    check_windows("stall");

    // Asynchronous reset with a window pending
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0, 0);
    #2;
    pulse_rst();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_D", 64'(out_D), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Reset mid-row discards the partial window
    for (int i = 1; i <= 3; i++) send(i, 1'b0, 0);
    #2;
    pulse_rst();
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    q = {10, 11, 12, 13, 14};
    send_row(q, 0);
    check_windows("post_rst");

    // Randomized rows with input gaps and random backpressure
    rnd_or = 1'b1;
    for (int r = 0; r < 40; r++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) q.push_back($urandom_range(0, 1023));
      send_row(q, 2);
    end
    rnd_or = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_windows("random");

`ifdef WC_FEEDER_CNT_EN
    chk("tile_cnt", 64'(tile_cnt), 64'(xfers[15:0]));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
